hangman_guess_engine: RTL

HANGMAN_GUESS_ENGINE -- requirements
Module: hangman_guess_engine

---
 rtl/hangman_pkg.sv | 20 ++
 rtl/hangman_match.sv | 25 ++
 rtl/hangman_guess_engine.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/hangman_pkg.sv
// Shared constants and FSM state type for the hangman guess engine.
// Letter codes: 0=A .. 25=Z; all-ones marks a blank position.
package hangman_pkg;

    localparam int LETTER_W_DEF = 5;
    localparam int LAST_LETTER  = 25;

    localparam logic [LETTER_W_DEF-1:0] BLANK = '1;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        READY,
        HELD,
        EVAL,
        WON,
        LOST
    } state_t;

endpackage

// File: rtl/hangman_match.sv
// Combinational letter matcher: flags every word position equal to guess.
// Ports: word (packed letters), guess (letter code), match (one bit per position).
module hangman_match
    import hangman_pkg::*;
#(
    parameter int WORD_LEN = 5,
    parameter int LETTER_W = LETTER_W_DEF
) (
    input  logic [WORD_LEN*LETTER_W-1:0] word,
    input  logic [LETTER_W-1:0]          guess,
    output logic [WORD_LEN-1:0]          match
);

    localparam logic [LETTER_W-1:0] BLANK_CODE = '1;

    always_comb begin
        match = '0;
        for (int i = 0; i < WORD_LEN; i++) begin
            // Blank positions are pre-revealed and must never count as a hit.
            match[i] = (word[i*LETTER_W +: LETTER_W] == guess)
                    && (word[i*LETTER_W +: LETTER_W] != BLANK_CODE);
        end
    end

endmodule

// File: rtl/hangman_guess_engine.sv
// Hangman game engine: latches a secret word, evaluates button-released guesses,
// tracks revealed positions, misses and win/loss.
// Ports: clk, resetn (async low), new_game, word, go, guess in;
//        revealed, misses, hit/miss/repeat strobes, won, lost, ready out.
module hangman_guess_engine
    import hangman_pkg::*;
#(
    parameter int WORD_LEN   = 5,
    parameter int LETTER_W   = LETTER_W_DEF,
    parameter int MAX_MISSES = 6
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         new_game,
    input  logic [WORD_LEN*LETTER_W-1:0] word,
    input  logic                         go,
    input  logic [LETTER_W-1:0]          guess,
    output logic [WORD_LEN-1:0]          revealed,
    output logic [3:0]                   misses,
    output logic                         hit_pulse,
    output logic                         miss_pulse,
    output logic                         repeat_pulse,
    output logic                         won,
    output logic                         lost,
    output logic                         ready
);

    localparam int                  NLET       = 2**LETTER_W;
    localparam logic [LETTER_W-1:0] BLANK_CODE = '1;
    localparam logic [LETTER_W-1:0] LAST_CODE  = LETTER_W'(LAST_LETTER);
    localparam logic [3:0]          MISS_LIMIT = 4'(MAX_MISSES);

    state_t                       state;
    logic [WORD_LEN*LETTER_W-1:0] word_q;
    logic [NLET-1:0]              bitmap;
    logic [LETTER_W-1:0]          guess_q;

    logic [WORD_LEN-1:0] match;
    logic [WORD_LEN-1:0] blank_mask;
    logic [WORD_LEN-1:0] rev_next;
    logic [3:0]          miss_next;
    logic                valid;
    logic                seen;
    logic                any_hit;
    state_t              eval_next;

    hangman_match #(
        .WORD_LEN (WORD_LEN),
        .LETTER_W (LETTER_W)
    ) u_match (
        .word  (word_q),
        .guess (guess_q),
        .match (match)
    );

    // Blank positions of the incoming word start out revealed.
    always_comb begin
        blank_mask = '0;
        for (int i = 0; i < WORD_LEN; i++) begin
            blank_mask[i] = (word[i*LETTER_W +: LETTER_W] == BLANK_CODE);
        end
    end

    // Result of the guess held in guess_q; the exit decision uses the
    // post-update revealed/misses so a winning or losing guess ends the game.
    always_comb begin
        valid     = (guess_q != BLANK_CODE) && (guess_q <= LAST_CODE);
        seen      = bitmap[guess_q];
        any_hit   = |match;
        rev_next  = revealed;
        miss_next = misses;
        if (valid && !seen) begin
            if (any_hit) begin
                rev_next = revealed | match;
            end else begin
                miss_next = misses + 4'd1;
            end
        end
        if (!valid) begin
            eval_next = READY;
        end else if (&rev_next) begin
            eval_next = WON;
        end else if (miss_next == MISS_LIMIT) begin
            eval_next = LOST;
        end else begin
            eval_next = READY;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            word_q       <= {WORD_LEN{BLANK_CODE}};
            bitmap       <= '0;
            guess_q      <= '0;
            revealed     <= '0;
            misses       <= '0;
            hit_pulse    <= 1'b0;
            miss_pulse   <= 1'b0;
            repeat_pulse <= 1'b0;
            won          <= 1'b0;
            lost         <= 1'b0;
            ready        <= 1'b0;
        end else begin
            hit_pulse    <= 1'b0;
            miss_pulse   <= 1'b0;
            repeat_pulse <= 1'b0;
            // new_game overrides any pending press or evaluation.
            if (new_game) begin
                state    <= ARM;
                word_q   <= word;
                bitmap   <= '0;
                revealed <= blank_mask;
                misses   <= '0;
                won      <= 1'b0;
                lost     <= 1'b0;
                ready    <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: ;
                    // Wait for release so a held button never submits.
                    ARM: if (!go) begin
                        state <= READY;
                        ready <= 1'b1;
                    end
                    READY: if (go) begin
                        state <= HELD;
                        ready <= 1'b0;
                    end
                    HELD: if (!go) begin
                        guess_q <= guess;
                        state   <= EVAL;
                    end
                    EVAL: begin
                        if (valid) begin
                            bitmap[guess_q] <= 1'b1;
                            repeat_pulse    <= seen;
                            hit_pulse       <= !seen && any_hit;
                            miss_pulse      <= !seen && !any_hit;
                        end
                        revealed <= rev_next;
                        misses   <= miss_next;
                        state    <= eval_next;
                        ready    <= (eval_next == READY);
                        won      <= (eval_next == WON);
                        lost     <= (eval_next == LOST);
                    end
                    WON, LOST: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
